exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute-stage controller that sits directly upstream of the 8-bit combinational ALU.
- Accepts 16-bit instructions over a valid/ready handshake and holds a 4-entry x 8-bit register file.
- Drives the ALU operand and opcode inputs, captures result/zero/carry, writes back, keeps the Z/C flag register and emits a one-cycle retire pulse.
- Non-pipelined: one instruction in flight at a time.

Parameters:
DATA_W, 8, datapath and register width; must match ALU width
REG_ADDR_W, 2, register index width (2**REG_ADDR_W registers)
INSTR_W, 16, instruction width = 4 + 2*REG_ADDR_W + DATA_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  stage can accept an instruction
instr  input  INSTR_W  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
alu_a  output  DATA_W  ALU operand a = R[rd]
alu_b  output  DATA_W  ALU operand b = R[rs]
alu_op  output  4  ALU opcode
alu_result  input  DATA_W  ALU result
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU carry/borrow
retire_valid  output  1  one-cycle retire pulse
retire_rd  output  REG_ADDR_W  destination of retired instruction
retire_data  output  DATA_W  value written (0 if illegal)
retire_illegal  output  1  retired instruction was illegal
flag_z  output  1  architectural zero flag
flag_c  output  1  architectural carry flag
dbg_addr  input  REG_ADDR_W  debug read index
dbg_data  output  DATA_W  combinational R[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all registers R0..R3 = 0; flag_z = flag_c = 0.
  - retire_* = 0; latched instruction = 0.
  - alu_a, alu_b and alu_op read 0.
- Opcodes 0000-0111 are ALU ops:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 shl1, 0110 shr1, 0111 eq.
- 1000 is LDI: rd <= imm, with no ALU use.
- 1001-1111 are illegal.
- FSM states: IDLE, EXEC, WB.
  - IDLE: instr_ready = 1. On instr_valid && instr_ready, latch instr. ALU op -> EXEC; LDI or illegal -> WB.
  - EXEC: instr_ready = 0. alu_a = R[rd_q], alu_b = R[rs_q], alu_op = op_q, all combinational. At the clock edge, capture alu_result, alu_zero and alu_carry into holding regs, then go to WB.
  - WB: instr_ready = 0.
    - ALU op: R[rd_q] <= captured result; flag_z <= captured zero; flag_c <= captured carry.
    - LDI: R[rd_q] <= imm; flags unchanged.
    - Illegal: no register write, flags unchanged.
    - In all cases, next state is IDLE.
- Retire outputs (registered): retire_valid = 1 for exactly the cycle after WB, together with retire_rd, retire_data and retire_illegal. They return to 0 the following cycle.
- Latency, counted from the accept edge to the edge at which retire_valid goes high: ALU op 3 cycles; LDI or illegal 2 cycles.
- Throughput: the next instruction can be accepted in the same cycle retire_valid is high, because the state is IDLE.
- Outside EXEC: alu_a, alu_b and alu_op drive 0.
- rd == rs: both operands read the same register; write-back overwrites that register.
- Width rules:
  - Carry for ops other than add/sub comes from the ALU (0) and is written to flag_c.
  - Sub carry = borrow (a < b unsigned).
- dbg_data reflects a write-back in the cycle after WB (no bypass).
- instr_valid while not ready: ignored. The upstream must hold it; instr may change freely while ready = 0.
- Reset mid-operation (EXEC/WB):
  - Instruction is abandoned; no retire pulse and no write.
  - All state returns to reset values immediately.

Decomposition:
- Package exec_pkg:
  - Opcode localparams (OP_ADD..OP_EQ, OP_LDI).
  - Instruction field positions.
  - State enum {IDLE, EXEC, WB}.
  - Function is_alu_op(op).
- Sub-module exec_regfile (2**REG_ADDR_W x DATA_W):
  - Two combinational read ports plus the debug read port.
  - One synchronous write port.
  - Async active-low clear.

Test Plan:
- Reset, then LDI R1,5 and LDI R2,3 -> retire_valid 2 cycles after each accept; dbg R1 = 5, R2 = 3; flags stay 0.
- SUB rd=R1, rs=R2 (5-3) -> alu_op = 0001 in EXEC, retire_data = 2, flag_z = 0, flag_c = 0; then SUB rd=R2, rs=R1 (3-2) -> R2 = 1, flag_c = 0.
- LDI R0,200; LDI R3,100; ADD R0,R3 -> R0 = 44, flag_c = 1, flag_z = 0; then XOR R0,R0 -> R0 = 0, flag_z = 1, flag_c = 0.
- instr op = 1010 -> retire_illegal = 1 after 2 cycles, retire_data = 0, no register or flag change.
- Back-to-back valid held high for 3 ALU ops -> instr_ready low during EXEC/WB; exactly 3 retire pulses, spaced 3 cycles apart.
- rst_n asserted during EXEC of ADD -> no retire pulse, registers and flags = 0, instr_ready = 1 after release.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, instruction field layout and FSM states.
// Instruction layout: [op | rd | rs | imm], MSB first.
package exec_pkg;

    localparam int unsigned OP_W        = 4;
    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned REG_IDX_W   = 2;
    localparam int unsigned IMM_LSB     = 0;
    localparam int unsigned RS_LSB      = IMM_LSB + DATA_WIDTH;
    localparam int unsigned RD_LSB      = RS_LSB + REG_IDX_W;
    localparam int unsigned OP_LSB      = RD_LSB + REG_IDX_W;
    localparam int unsigned INSTR_WIDTH = OP_LSB + OP_W;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_SHL = 4'h5;
    localparam logic [OP_W-1:0] OP_SHR = 4'h6;
    localparam logic [OP_W-1:0] OP_EQ  = 4'h7;
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

    // The whole lower half of the opcode space is handed to the ALU.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return !op[OP_W-1];
    endfunction

endpackage

// File: rtl/exec_if.sv
// Bundle of the execute stage's instruction handshake, ALU bus, retire, flag and debug signals.
// slave is the execute stage; master is the upstream/ALU/debug side.
interface exec_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_ADDR_W = 2,
    parameter int unsigned INSTR_W    = 16
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [INSTR_W-1:0]    instr;
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [3:0]            alu_op;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_zero;
    logic                  alu_carry;
    logic                  retire_valid;
    logic [REG_ADDR_W-1:0] retire_rd;
    logic [DATA_W-1:0]     retire_data;
    logic                  retire_illegal;
    logic                  flag_z;
    logic                  flag_c;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    modport master (
        output instr_valid, instr, alu_result, alu_zero, alu_carry, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, retire_valid, retire_rd, retire_data,
               retire_illegal, flag_z, flag_c, dbg_data
    );

    modport slave (
        input  instr_valid, instr, alu_result, alu_zero, alu_carry, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, retire_valid, retire_rd, retire_data,
               retire_illegal, flag_z, flag_c, dbg_data
    );
endinterface

// File: rtl/exec_regfile.sv
// Small register file: two combinational operand read ports, one debug read port,
// one synchronous write port, asynchronously cleared.
module exec_regfile #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0]     ra_data,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0]     rb_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata
);
    localparam int unsigned NREGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign ra_data  = regs_q[ra_addr];
    assign rb_data  = regs_q[rb_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/exec_stage.sv
// Non-pipelined execute stage in front of an 8-bit combinational ALU: accepts one instruction,
// runs it through IDLE -> [EXEC] -> WB, writes back, updates Z/C and pulses retire.
module exec_stage import exec_pkg::*; #(
    parameter int unsigned DATA_W     = DATA_WIDTH,
    parameter int unsigned REG_ADDR_W = REG_IDX_W,
    parameter int unsigned INSTR_W    = INSTR_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    exec_if.slave bus
);
    state_e                state_q;
    logic [INSTR_W-1:0]    instr_q;
    logic [DATA_W-1:0]     res_q;
    logic                  zero_q;
    logic                  carry_q;
    logic                  flag_z_q;
    logic                  flag_c_q;
    logic                  retire_valid_q;
    logic [REG_ADDR_W-1:0] retire_rd_q;
    logic [DATA_W-1:0]     retire_data_q;
    logic                  retire_illegal_q;

    logic [OP_W-1:0]       op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [DATA_W-1:0]     imm_q;
    logic                  alu_q;
    logic                  illegal_q;
    logic [DATA_W-1:0]     ra_data;
    logic [DATA_W-1:0]     rb_data;
    logic                  wb_we;
    logic [DATA_W-1:0]     wb_data;
    logic                  in_exec;

    assign op_q      = instr_q[OP_LSB +: OP_W];
    assign rd_q      = instr_q[RD_LSB +: REG_ADDR_W];
    assign rs_q      = instr_q[RS_LSB +: REG_ADDR_W];
    assign imm_q     = instr_q[IMM_LSB +: DATA_W];
    assign alu_q     = is_alu_op(op_q);
    assign illegal_q = !alu_q && (op_q != OP_LDI);

    assign wb_we   = (state_q == WB) && !illegal_q;
    assign wb_data = alu_q ? res_q : imm_q;

    exec_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (rd_q),
        .ra_data  (ra_data),
        .rb_addr  (rs_q),
        .rb_data  (rb_data),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data),
        .we       (wb_we),
        .waddr    (rd_q),
        .wdata    (wb_data)
    );

    // ALU inputs are only meaningful in EXEC; elsewhere they are held at zero.
    assign in_exec     = (state_q == EXEC);
    assign bus.alu_a   = in_exec ? ra_data : '0;
    assign bus.alu_b   = in_exec ? rb_data : '0;
    assign bus.alu_op  = in_exec ? op_q : '0;

    assign bus.instr_ready    = (state_q == IDLE);
    assign bus.flag_z         = flag_z_q;
    assign bus.flag_c         = flag_c_q;
    assign bus.retire_valid   = retire_valid_q;
    assign bus.retire_rd      = retire_rd_q;
    assign bus.retire_data    = retire_data_q;
    assign bus.retire_illegal = retire_illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            instr_q          <= '0;
            res_q            <= '0;
            zero_q           <= 1'b0;
            carry_q          <= 1'b0;
            flag_z_q         <= 1'b0;
            flag_c_q         <= 1'b0;
            retire_valid_q   <= 1'b0;
            retire_rd_q      <= '0;
            retire_data_q    <= '0;
            retire_illegal_q <= 1'b0;
        end else begin
            retire_valid_q   <= 1'b0;
            retire_rd_q      <= '0;
            retire_data_q    <= '0;
            retire_illegal_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state_q <= is_alu_op(bus.instr[OP_LSB +: OP_W]) ? EXEC : WB;
                    end
                end
                EXEC: begin
                    res_q   <= bus.alu_result;
                    zero_q  <= bus.alu_zero;
                    carry_q <= bus.alu_carry;
                    state_q <= WB;
                end
                WB: begin
                    if (alu_q) begin
                        flag_z_q <= zero_q;
                        flag_c_q <= carry_q;
                    end
                    retire_valid_q   <= 1'b1;
                    retire_rd_q      <= rd_q;
                    retire_data_q    <= illegal_q ? '0 : wb_data;
                    retire_illegal_q <= illegal_q;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage; the bench also plays the combinational ALU.
module tb_exec_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    logic [8:0] alu_wide;

    exec_if #(.DATA_W(8), .REG_ADDR_W(2), .INSTR_W(16)) bus ();

    exec_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: bit 8 of the widened result is carry for add, borrow for sub.
    always_comb begin
        alu_wide = '0;
        case (bus.alu_op)
            4'h0:    alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'h1:    alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            4'h2:    alu_wide = {1'b0, bus.alu_a & bus.alu_b};
            4'h3:    alu_wide = {1'b0, bus.alu_a | bus.alu_b};
            4'h4:    alu_wide = {1'b0, bus.alu_a ^ bus.alu_b};
            4'h5:    alu_wide = {1'b0, bus.alu_a << 1};
            4'h6:    alu_wide = {1'b0, bus.alu_a >> 1};
            4'h7:    alu_wide = {8'd0, bus.alu_a == bus.alu_b};
            default: alu_wide = '0;
        endcase
        bus.alu_result = alu_wide[7:0];
        bus.alu_carry  = alu_wide[8];
        bus.alu_zero   = (alu_wide[7:0] == 8'd0);
    end

    // Offer one instruction, then count edges (accept edge = 1) until retire_valid rises.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, output int lat, output logic [3:0] exec_op,
                         output logic [7:0] rdata, output logic [1:0] rrd, output logic rill);
        @(negedge clk);
        bus.instr       = {op, rd, rs, imm};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        exec_op = bus.alu_op;
        lat     = 1;
        rdata   = '0;
        rrd     = '0;
        rill    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.retire_valid) begin
                rdata = bus.retire_data;
                rrd   = bus.retire_rd;
                rill  = bus.retire_illegal;
                break;
            end
        end
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
        bus.dbg_addr = idx;
        #1;
        val = bus.dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.dbg_addr    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.instr_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.instr_ready); else passed++;
        checks++; if (bus.retire_valid !== 1'b0) $display("FAIL rst_retire: got %b want 0", bus.retire_valid); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {bus.flag_z, bus.flag_c}); else passed++;
        checks++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 20'd0) $display("FAIL rst_alu: got %h want 0", {bus.alu_op, bus.alu_a, bus.alu_b}); else passed++;
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], v);
            checks++; if (v !== 8'd0) $display("FAIL rst_reg%0d: got %0d want 0", r, v); else passed++;
        end
    endtask

    task automatic test_ldi();
        int lat; logic [3:0] eop; logic [7:0] d; logic [1:0] rrd; logic ill; logic [7:0] v;
        issue(4'h8, 2'd1, 2'd0, 8'd5, lat, eop, d, rrd, ill);
        checks++; if (lat !== 2) $display("FAIL ldi1_lat: got %0d want 2", lat); else passed++;
        checks++; if ({rrd, d, ill} !== {2'd1, 8'd5, 1'b0}) $display("FAIL ldi1_retire: got rd=%0d data=%0d ill=%b want rd=1 data=5 ill=0", rrd, d, ill); else passed++;
        checks++; if (eop !== 4'h0) $display("FAIL ldi1_aluop: got %h want 0", eop); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.retire_valid !== 1'b0) $display("FAIL ldi1_pulse_width: got %b want 0", bus.retire_valid); else passed++;
        issue(4'h8, 2'd2, 2'd0, 8'd3, lat, eop, d, rrd, ill);
        checks++; if (lat !== 2) $display("FAIL ldi2_lat: got %0d want 2", lat); else passed++;
        read_reg(2'd1, v);
        checks++; if (v !== 8'd5) $display("FAIL ldi_r1: got %0d want 5", v); else passed++;
        read_reg(2'd2, v);
        checks++; if (v !== 8'd3) $display("FAIL ldi_r2: got %0d want 3", v); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) $display("FAIL ldi_flags: got %b want 00", {bus.flag_z, bus.flag_c}); else passed++;
    endtask

    task automatic test_sub();
        int lat; logic [3:0] eop; logic [7:0] d; logic [1:0] rrd; logic ill; logic [7:0] v;
        issue(4'h1, 2'd1, 2'd2, 8'd0, lat, eop, d, rrd, ill);
        checks++; if (eop !== 4'h1) $display("FAIL sub1_aluop: got %h want 1", eop); else passed++;
        checks++; if (lat !== 3) $display("FAIL sub1_lat: got %0d want 3", lat); else passed++;
        checks++; if ({rrd, d} !== {2'd1, 8'd2}) $display("FAIL sub1_retire: got rd=%0d data=%0d want rd=1 data=2", rrd, d); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) $display("FAIL sub1_flags: got %b want 00", {bus.flag_z, bus.flag_c}); else passed++;
        issue(4'h1, 2'd2, 2'd1, 8'd0, lat, eop, d, rrd, ill);
        read_reg(2'd2, v);
        checks++; if (v !== 8'd1) $display("FAIL sub2_r2: got %0d want 1", v); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) $display("FAIL sub2_flags: got %b want 00", {bus.flag_z, bus.flag_c}); else passed++;
    endtask

    task automatic test_add_carry();
        int lat; logic [3:0] eop; logic [7:0] d; logic [1:0] rrd; logic ill; logic [7:0] v;
        issue(4'h8, 2'd0, 2'd0, 8'd200, lat, eop, d, rrd, ill);
        issue(4'h8, 2'd3, 2'd0, 8'd100, lat, eop, d, rrd, ill);
        issue(4'h0, 2'd0, 2'd3, 8'd0, lat, eop, d, rrd, ill);
        checks++; if (d !== 8'd44) $display("FAIL add_data: got %0d want 44", d); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b01) $display("FAIL add_flags: got %b want 01", {bus.flag_z, bus.flag_c}); else passed++;
        issue(4'h4, 2'd0, 2'd0, 8'd0, lat, eop, d, rrd, ill);
        read_reg(2'd0, v);
        checks++; if (v !== 8'd0) $display("FAIL xor_r0: got %0d want 0", v); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b10) $display("FAIL xor_flags: got %b want 10", {bus.flag_z, bus.flag_c}); else passed++;
    endtask

    task automatic test_illegal();
        int lat; logic [3:0] eop; logic [7:0] d; logic [1:0] rrd; logic ill; logic [7:0] v;
        issue(4'hA, 2'd3, 2'd0, 8'h55, lat, eop, d, rrd, ill);
        checks++; if (lat !== 2) $display("FAIL ill_lat: got %0d want 2", lat); else passed++;
        checks++; if ({ill, d} !== {1'b1, 8'd0}) $display("FAIL ill_retire: got ill=%b data=%0d want ill=1 data=0", ill, d); else passed++;
        read_reg(2'd3, v);
        checks++; if (v !== 8'd100) $display("FAIL ill_r3: got %0d want 100", v); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b10) $display("FAIL ill_flags: got %b want 10", {bus.flag_z, bus.flag_c}); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        int acc_cyc [3];
        int ret_cyc [3];
        int idx, n_ret, low_cnt;
        logic rdy, offered;
        logic [7:0] v;
        prog[0] = {4'h0, 2'd1, 2'd2, 8'd0};   // ADD R1,R2 -> 3
        prog[1] = {4'h3, 2'd0, 2'd3, 8'd0};   // OR  R0,R3 -> 100
        prog[2] = {4'h2, 2'd3, 2'd1, 8'd0};   // AND R3,R1 -> 0
        idx = 0; n_ret = 0; low_cnt = 0;
        acc_cyc = '{default: 0};
        ret_cyc = '{default: 0};
        bus.instr       = prog[0];
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            rdy     = bus.instr_ready;
            offered = bus.instr_valid;
            if (!rdy) low_cnt++;
            @(posedge clk);
            #1;
            if (bus.retire_valid) begin
                if (n_ret < 3) ret_cyc[n_ret] = c;
                n_ret++;
            end
            if (rdy && offered && idx < 3) begin
                acc_cyc[idx] = c;
                idx++;
                if (idx < 3) bus.instr = prog[idx];
                else bus.instr_valid = 1'b0;
            end
        end
        checks++; if (n_ret !== 3) $display("FAIL b2b_count: got %0d want 3", n_ret); else passed++;
        checks++; if (low_cnt !== 6) $display("FAIL b2b_ready_low: got %0d want 6", low_cnt); else passed++;
        checks++; if (ret_cyc[1] - ret_cyc[0] !== 3) $display("FAIL b2b_space01: got %0d want 3", ret_cyc[1] - ret_cyc[0]); else passed++;
        checks++; if (ret_cyc[2] - ret_cyc[1] !== 3) $display("FAIL b2b_space12: got %0d want 3", ret_cyc[2] - ret_cyc[1]); else passed++;
        checks++; if (ret_cyc[0] - acc_cyc[0] !== 2) $display("FAIL b2b_first: got %0d want 2", ret_cyc[0] - acc_cyc[0]); else passed++;
        read_reg(2'd1, v);
        checks++; if (v !== 8'd3) $display("FAIL b2b_r1: got %0d want 3", v); else passed++;
        read_reg(2'd0, v);
        checks++; if (v !== 8'd100) $display("FAIL b2b_r0: got %0d want 100", v); else passed++;
        read_reg(2'd3, v);
        checks++; if (v !== 8'd0) $display("FAIL b2b_r3: got %0d want 0", v); else passed++;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b10) $display("FAIL b2b_flags: got %b want 10", {bus.flag_z, bus.flag_c}); else passed++;
    endtask

    task automatic test_reset_mid();
        int n_ret;
        logic [7:0] v;
        @(negedge clk);
        bus.instr       = {4'h0, 2'd0, 2'd1, 8'd0};   // ADD R0,R1 = 100+3
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        checks++; if (bus.alu_a !== 8'd100) $display("FAIL mid_exec_a: got %0d want 100", bus.alu_a); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) $display("FAIL mid_flags: got %b want 00", {bus.flag_z, bus.flag_c}); else passed++;
        read_reg(2'd0, v);
        checks++; if (v !== 8'd0) $display("FAIL mid_r0: got %0d want 0", v); else passed++;
        read_reg(2'd1, v);
        checks++; if (v !== 8'd0) $display("FAIL mid_r1: got %0d want 0", v); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_ret = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.retire_valid) n_ret++;
        end
        checks++; if (n_ret !== 0) $display("FAIL mid_no_retire: got %0d want 0", n_ret); else passed++;
        checks++; if (bus.instr_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", bus.instr_ready); else passed++;
        read_reg(2'd0, v);
        checks++; if (v !== 8'd0) $display("FAIL mid_r0_after: got %0d want 0", v); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_ldi();
        test_sub();
        test_add_carry();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
